// File: rtl/can_rx_if.sv
// can_rx_if: bus pin and decoded-frame bundle between the CAN receiver and its consumer.
interface can_rx_if;
   logic        rx_i;
   logic        tx_o;
   logic        rx_valid_o;
   logic        rx_match_o;
   logic        rx_error_o;
   logic [1:0]  rx_error_code_o;
   logic        rx_busy_o;
   logic        message_type_o;
   logic [5:0]  local_address_o;
   logic [5:0]  remote_address_o;
   logic [1:0]  handshake_o;
   logic [1:0]  atribute_o;
   logic [3:0]  expand_count_o;
   logic [7:0]  cmd_data_sign_o;
   logic        rtr_o;
   logic [3:0]  dlc_o;
   logic [63:0] rx_data_o;

   // Receiver side: samples the bus, drives ACK and the decoded fields
   modport slave (
      input  rx_i,
      output tx_o, rx_valid_o, rx_match_o, rx_error_o, rx_error_code_o, rx_busy_o,
      output message_type_o, local_address_o, remote_address_o, handshake_o,
      output atribute_o, expand_count_o, cmd_data_sign_o, rtr_o, dlc_o, rx_data_o
   );

   // Consumer side: provides the bus level, reads the results
   modport master (
      output rx_i,
      input  tx_o, rx_valid_o, rx_match_o, rx_error_o, rx_error_code_o, rx_busy_o,
      input  message_type_o, local_address_o, remote_address_o, handshake_o,
      input  atribute_o, expand_count_o, cmd_data_sign_o, rtr_o, dlc_o, rx_data_o
   );
endinterface

// File: rtl/can_rx.sv
// can_rx: bit-level receiver for the extended-identifier CAN frame format.
// One bit per clk_can_i cycle: destuffs, checks CRC and fixed-form bits,
// drives the dominant ACK and presents the decoded fields with a valid strobe.
module can_rx #(
   parameter logic [5:0] NODE_ADDRESS = 6'h00
) (
   input  logic    clk_can_i,
   input  logic    rst_i,
   can_rx_if.slave bus
);

   typedef enum logic [4:0] {
      ST_IDLE, ST_SOF, ST_MSG_TYPE, ST_ADDR_LOCAL, ST_ADDR_REMOTE, ST_SRR, ST_IDE,
      ST_HANDSHAKE, ST_ATRIBUTE, ST_EXPAND, ST_CMD_SIGN, ST_RTR, ST_RESERVED, ST_DLC,
      ST_DATA, ST_CRC, ST_CRC_DELIM, ST_ACK_SLOT, ST_ACK_DELIM, ST_EOF, ST_ERROR
   } state_e;

   localparam logic [1:0]  ERR_STUFF = 2'b01;
   localparam logic [1:0]  ERR_CRC   = 2'b10;
   localparam logic [1:0]  ERR_FORM  = 2'b11;
   localparam logic [14:0] CRC_POLY  = 15'h4599;

   // Sequencing state
   state_e      state_q;
   logic [6:0]  count_q;
   logic        run_pol_q;
   logic [2:0]  run_len_q;
   logic [14:0] crc_q;
   logic [14:0] crc_rx_q;
   logic        crc_ok_q;

   // Fields being assembled for the frame in progress
   logic        mt_q;
   logic [5:0]  loc_q;
   logic [5:0]  rem_q;
   logic [1:0]  hs_q;
   logic [1:0]  at_q;
   logic [3:0]  exp_q;
   logic [7:0]  cmd_q;
   logic        rtr_q;
   logic [3:0]  dlc_q;
   logic [63:0] data_q;

   // Registered outputs
   logic        tx_q;
   logic        valid_q;
   logic        error_q;
   logic        match_q;
   logic [1:0]  err_code_q;
   logic        o_mt_q;
   logic [5:0]  o_loc_q;
   logic [5:0]  o_rem_q;
   logic [1:0]  o_hs_q;
   logic [1:0]  o_at_q;
   logic [3:0]  o_exp_q;
   logic [7:0]  o_cmd_q;
   logic        o_rtr_q;
   logic [3:0]  o_dlc_q;
   logic [63:0] o_data_q;

   // Per-bit decisions derived from the current state and the sampled level
   logic        stuff_region_d;
   logic        crc_region_d;
   logic        stuff_bit_d;
   logic        stuff_err_d;
   logic        form_err_d;
   logic        crc_feed_d;
   logic        run_pol_d;
   logic [2:0]  run_len_d;
   logic        crc_fb_d;
   logic [14:0] crc_d;

   // Destuffing, form-check and CRC-update decode for the bit on the bus
   always_comb begin
      stuff_region_d = state_q inside {ST_MSG_TYPE, ST_ADDR_LOCAL, ST_ADDR_REMOTE, ST_SRR,
                                       ST_IDE, ST_HANDSHAKE, ST_ATRIBUTE, ST_EXPAND,
                                       ST_CMD_SIGN, ST_RTR, ST_RESERVED, ST_DLC, ST_DATA,
                                       ST_CRC};
      crc_region_d   = stuff_region_d && (state_q != ST_CRC);
      stuff_bit_d    = stuff_region_d && (run_len_q == 3'd5);
      stuff_err_d    = stuff_bit_d && (bus.rx_i == run_pol_q);
      form_err_d     = !stuff_bit_d && !bus.rx_i &&
                       (state_q inside {ST_SRR, ST_IDE, ST_CRC_DELIM, ST_ACK_DELIM, ST_EOF});
      crc_feed_d     = crc_region_d && !stuff_bit_d;

      run_pol_d = bus.rx_i;
      run_len_d = 3'd1;
      if (!stuff_bit_d && (bus.rx_i == run_pol_q)) begin
         run_len_d = run_len_q + 3'd1;
      end

      crc_fb_d = bus.rx_i ^ crc_q[14];
      crc_d    = {crc_q[13:0], 1'b0} ^ (crc_fb_d ? CRC_POLY : '0);
   end

   // Receive FSM: field capture, error entry/recovery, ACK drive and result strobes
   always_ff @(posedge clk_can_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         run_pol_q  <= 1'b1;
         run_len_q  <= '0;
         crc_q      <= '0;
         crc_rx_q   <= '0;
         crc_ok_q   <= 1'b0;
         mt_q       <= 1'b0;
         loc_q      <= '0;
         rem_q      <= '0;
         hs_q       <= '0;
         at_q       <= '0;
         exp_q      <= '0;
         cmd_q      <= '0;
         rtr_q      <= 1'b0;
         dlc_q      <= '0;
         data_q     <= '0;
         tx_q       <= 1'b1;
         valid_q    <= 1'b0;
         error_q    <= 1'b0;
         match_q    <= 1'b0;
         err_code_q <= '0;
         o_mt_q     <= 1'b0;
         o_loc_q    <= '0;
         o_rem_q    <= '0;
         o_hs_q     <= '0;
         o_at_q     <= '0;
         o_exp_q    <= '0;
         o_cmd_q    <= '0;
         o_rtr_q    <= 1'b0;
         o_dlc_q    <= '0;
         o_data_q   <= '0;
      end else begin
         tx_q    <= 1'b1;
         valid_q <= 1'b0;
         error_q <= 1'b0;

         if (stuff_region_d) begin
            run_pol_q <= run_pol_d;
            run_len_q <= run_len_d;
         end
         if (crc_feed_d) begin
            crc_q <= crc_d;
         end

         // A bad stuff bit is never a field bit, so it takes priority over form checks
         if (stuff_err_d) begin
            state_q    <= ST_ERROR;
            count_q    <= '0;
            error_q    <= 1'b1;
            err_code_q <= ERR_STUFF;
         end else if (form_err_d) begin
            state_q    <= ST_ERROR;
            count_q    <= '0;
            error_q    <= 1'b1;
            err_code_q <= ERR_FORM;
         end else if (!stuff_bit_d) begin
            case (state_q)
               ST_IDLE: begin
                  if (!bus.rx_i) begin
                     state_q   <= ST_MSG_TYPE;
                     count_q   <= '0;
                     run_pol_q <= 1'b0;
                     run_len_q <= 3'd1;
                     crc_q     <= '0;
                     crc_ok_q  <= 1'b0;
                  end
               end
               ST_MSG_TYPE: begin
                  mt_q    <= bus.rx_i;
                  state_q <= ST_ADDR_LOCAL;
               end
               ST_ADDR_LOCAL: begin
                  loc_q <= {loc_q[4:0], bus.rx_i};
                  if (count_q == 7'd5) begin
                     state_q <= ST_ADDR_REMOTE;
                     count_q <= '0;
                  end else begin
                     count_q <= count_q + 7'd1;
                  end
               end
               // count keeps running across the SRR/IDE detour so the field resumes at bit 4
               ST_ADDR_REMOTE: begin
                  rem_q <= {rem_q[4:0], bus.rx_i};
                  if (count_q == 7'd3) begin
                     state_q <= ST_SRR;
                     count_q <= 7'd4;
                  end else if (count_q == 7'd5) begin
                     state_q <= ST_HANDSHAKE;
                     count_q <= '0;
                  end else begin
                     count_q <= count_q + 7'd1;
                  end
               end
               ST_SRR: state_q <= ST_IDE;
               ST_IDE: state_q <= ST_ADDR_REMOTE;
               ST_HANDSHAKE: begin
                  hs_q <= {hs_q[0], bus.rx_i};
                  if (count_q == 7'd1) begin
                     state_q <= ST_ATRIBUTE;
                     count_q <= '0;
                  end else begin
                     count_q <= count_q + 7'd1;
                  end
               end
               ST_ATRIBUTE: begin
                  at_q <= {at_q[0], bus.rx_i};
                  if (count_q == 7'd1) begin
                     state_q <= ST_EXPAND;
                     count_q <= '0;
                  end else begin
                     count_q <= count_q + 7'd1;
                  end
               end
               ST_EXPAND: begin
                  exp_q <= {exp_q[2:0], bus.rx_i};
                  if (count_q == 7'd3) begin
                     state_q <= ST_CMD_SIGN;
                     count_q <= '0;
                  end else begin
                     count_q <= count_q + 7'd1;
                  end
               end
               ST_CMD_SIGN: begin
                  cmd_q <= {cmd_q[6:0], bus.rx_i};
                  if (count_q == 7'd7) begin
                     state_q <= ST_RTR;
                     count_q <= '0;
                  end else begin
                     count_q <= count_q + 7'd1;
                  end
               end
               ST_RTR: begin
                  rtr_q   <= bus.rx_i;
                  state_q <= ST_RESERVED;
               end
               ST_RESERVED: begin
                  if (count_q == 7'd1) begin
                     state_q <= ST_DLC;
                     count_q <= '0;
                  end else begin
                     count_q <= count_q + 7'd1;
                  end
               end
               ST_DLC: begin
                  dlc_q <= {dlc_q[2:0], bus.rx_i};
                  if (count_q == 7'd3) begin
                     state_q <= ST_DATA;
                     count_q <= '0;
                  end else begin
                     count_q <= count_q + 7'd1;
                  end
               end
               ST_DATA: begin
                  data_q <= {data_q[62:0], bus.rx_i};
                  if (count_q == 7'd63) begin
                     state_q <= ST_CRC;
                     count_q <= '0;
                  end else begin
                     count_q <= count_q + 7'd1;
                  end
               end
               ST_CRC: begin
                  crc_rx_q <= {crc_rx_q[13:0], bus.rx_i};
                  if (count_q == 7'd14) begin
                     crc_ok_q <= ({crc_rx_q[13:0], bus.rx_i} == crc_q);
                     state_q  <= ST_CRC_DELIM;
                     count_q  <= '0;
                  end else begin
                     count_q <= count_q + 7'd1;
                  end
               end
               ST_CRC_DELIM: begin
                  state_q <= ST_ACK_SLOT;
                  tx_q    <= ~crc_ok_q;
               end
               // A CRC mismatch still rides through the ACK slot before reporting
               ST_ACK_SLOT: begin
                  if (crc_ok_q) begin
                     state_q <= ST_ACK_DELIM;
                  end else begin
                     state_q    <= ST_ERROR;
                     count_q    <= '0;
                     error_q    <= 1'b1;
                     err_code_q <= ERR_CRC;
                  end
               end
               ST_ACK_DELIM: begin
                  state_q <= ST_EOF;
                  count_q <= '0;
               end
               ST_EOF: begin
                  if (count_q == 7'd6) begin
                     state_q  <= ST_IDLE;
                     count_q  <= '0;
                     valid_q  <= 1'b1;
                     match_q  <= (rem_q == NODE_ADDRESS);
                     o_mt_q   <= mt_q;
                     o_loc_q  <= loc_q;
                     o_rem_q  <= rem_q;
                     o_hs_q   <= hs_q;
                     o_at_q   <= at_q;
                     o_exp_q  <= exp_q;
                     o_cmd_q  <= cmd_q;
                     o_rtr_q  <= rtr_q;
                     o_dlc_q  <= dlc_q;
                     o_data_q <= data_q;
                  end else begin
                     count_q <= count_q + 7'd1;
                  end
               end
               ST_ERROR: begin
                  if (!bus.rx_i) begin
                     count_q <= '0;
                  end else if (count_q == 7'd10) begin
                     state_q <= ST_IDLE;
                     count_q <= '0;
                  end else begin
                     count_q <= count_q + 7'd1;
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
                  count_q <= '0;
               end
            endcase
         end
      end
   end

   assign bus.tx_o             = tx_q;
   assign bus.rx_valid_o       = valid_q;
   assign bus.rx_match_o       = match_q;
   assign bus.rx_error_o       = error_q;
   assign bus.rx_error_code_o  = err_code_q;
   assign bus.rx_busy_o        = (state_q != ST_IDLE);
   assign bus.message_type_o   = o_mt_q;
   assign bus.local_address_o  = o_loc_q;
   assign bus.remote_address_o = o_rem_q;
   assign bus.handshake_o      = o_hs_q;
   assign bus.atribute_o       = o_at_q;
   assign bus.expand_count_o   = o_exp_q;
   assign bus.cmd_data_sign_o  = o_cmd_q;
   assign bus.rtr_o            = o_rtr_q;
   assign bus.dlc_o            = o_dlc_q;
   assign bus.rx_data_o        = o_data_q;

endmodule

// File: tb/tb_can_rx.sv
// tb_can_rx: frame-level bench for can_rx. A behavioural model builds each wire
// frame (CRC, stuffing, tail) and the expected per-bit outputs; one compare
// process checks every DUT output every cycle.
module tb_can_rx;

   localparam logic [5:0] NODE = 6'h2A;

   typedef struct packed {
      logic        mt;
      logic [5:0]  loc;
      logic [5:0]  rem;
      logic [1:0]  hs;
      logic [1:0]  at;
      logic [3:0]  ex;
      logic [7:0]  cmd;
      logic        rtr;
      logic [3:0]  dlc;
      logic [63:0] data;
   } fld_t;

   typedef struct packed {
      logic rx;
      logic tx;
      logic valid;
      logic err;
      logic busy;
   } step_t;

   typedef enum {K_GOOD, K_CRC, K_STUFF, K_DELIM, K_EOF} kind_e;

   logic clk = 1'b0;
   logic rst = 1'b1;
   can_rx_if bus ();

   can_rx #(.NODE_ADDRESS(NODE)) dut (
      .clk_can_i (clk),
      .rst_i     (rst),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   // Expected outputs for the cycle following the current negedge drive
   logic       e_tx    = 1'b1;
   logic       e_valid = 1'b0;
   logic       e_err   = 1'b0;
   logic       e_busy  = 1'b0;
   logic       e_match = 1'b0;
   logic [1:0] e_code  = 2'b00;
   fld_t       e_fld   = '0;

   bit    raw_q[$];
   bit    wire_q[$];
   bit    stf_q[$];
   step_t plan[$];
   fld_t  plan_fld;
   logic [1:0] plan_code;

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
      end
   endtask

   function automatic logic [14:0] crc_step(input logic [14:0] c, input bit b);
      logic nx;
      nx = b ^ c[14];
      return {c[13:0], 1'b0} ^ (nx ? 15'h4599 : 15'h0000);
   endfunction

   task automatic push_bits(input logic [63:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) raw_q.push_back(v[i]);
   endtask

   // Insert a complement bit after every run of five, only ahead of a following bit
   task automatic do_stuff();
      bit pol;
      int run;
      wire_q.delete();
      stf_q.delete();
      pol = 1'b0;
      run = 0;
      foreach (raw_q[i]) begin
         if (run == 5) begin
            wire_q.push_back(!pol);
            stf_q.push_back(1'b1);
            pol = !pol;
            run = 1;
         end
         wire_q.push_back(raw_q[i]);
         stf_q.push_back(1'b0);
         if (run != 0 && raw_q[i] == pol) run++;
         else begin
            pol = raw_q[i];
            run = 1;
         end
      end
   endtask

   task automatic build_raw(input fld_t f);
      raw_q.delete();
      raw_q.push_back(1'b0);
      push_bits(64'(f.mt), 1);
      push_bits(64'(f.loc), 6);
      push_bits(64'(f.rem[5:2]), 4);
      push_bits(64'(1), 1);
      push_bits(64'(1), 1);
      push_bits(64'(f.rem[1:0]), 2);
      push_bits(64'(f.hs), 2);
      push_bits(64'(f.at), 2);
      push_bits(64'(f.ex), 4);
      push_bits(64'(f.cmd), 8);
      push_bits(64'(f.rtr), 1);
      push_bits(64'(0), 2);
      push_bits(64'(f.dlc), 4);
      push_bits(f.data, 64);
   endtask

   task automatic build(input fld_t f, input kind_e kind);
      logic [14:0] crc;
      bit    wb[$];
      int    body, err_idx, last;
      bit    has_err;
      bit    tx0_ok;
      step_t s;
      build_raw(f);
      crc = '0;
      for (int i = 1; i < raw_q.size(); i++) crc = crc_step(crc, raw_q[i]);
      if (kind == K_CRC) raw_q[raw_q.size() - 1] = !raw_q[raw_q.size() - 1];
      push_bits(64'(crc), 15);
      do_stuff();
      body = wire_q.size();
      wb = wire_q;
      wb.push_back(1'b1);
      wb.push_back((kind == K_GOOD || kind == K_EOF) ? 1'b0 : 1'b1);
      wb.push_back(1'b1);
      for (int i = 0; i < 7; i++) wb.push_back(1'b1);
      has_err = (kind != K_GOOD);
      err_idx = 0;
      case (kind)
         K_STUFF: begin
            foreach (stf_q[i]) if (stf_q[i] && err_idx == 0) err_idx = i;
            wb[err_idx] = wb[err_idx - 1];
            plan_code = 2'b01;
         end
         K_CRC: begin
            err_idx = body + 1;
            plan_code = 2'b10;
         end
         K_DELIM: begin
            err_idx = body;
            wb[err_idx] = 1'b0;
            plan_code = 2'b11;
         end
         K_EOF: begin
            err_idx = body + 6;
            wb[err_idx] = 1'b0;
            plan_code = 2'b11;
         end
         default: plan_code = 2'b00;
      endcase
      tx0_ok = (kind == K_GOOD || kind == K_EOF);
      last = has_err ? err_idx : wb.size() - 1;
      plan.delete();
      for (int k = 0; k <= last; k++) begin
         s.rx    = wb[k];
         s.tx    = !(tx0_ok && k == body);
         s.valid = !has_err && k == last;
         s.err   = has_err && k == err_idx;
         s.busy  = !s.valid;
         plan.push_back(s);
      end
      if (has_err) begin
         for (int j = 1; j <= 11; j++) begin
            s.rx = 1'b1; s.tx = 1'b1; s.valid = 1'b0; s.err = 1'b0;
            s.busy = (j < 11);
            plan.push_back(s);
         end
      end
      plan_fld = f;
   endtask

   task automatic play(input int limit);
      for (int k = 0; k < plan.size() && k < limit; k++) begin
         @(negedge clk);
         bus.rx_i = plan[k].rx;
         e_tx     = plan[k].tx;
         e_valid  = plan[k].valid;
         e_err    = plan[k].err;
         e_busy   = plan[k].busy;
         if (plan[k].valid) begin
            e_fld   = plan_fld;
            e_match = (plan_fld.rem == NODE);
         end
         if (plan[k].err) e_code = plan_code;
      end
   endtask

   task automatic set_idle();
      e_tx = 1'b1; e_valid = 1'b0; e_err = 1'b0; e_busy = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.rx_i = 1'b1;
         set_idle();
      end
   endtask

   task automatic do_reset(input int n);
      repeat (n) begin
         @(negedge clk);
         rst = 1'b1;
         bus.rx_i = 1'b1;
         set_idle();
         e_fld = '0; e_match = 1'b0; e_code = 2'b00;
      end
      @(negedge clk);
      rst = 1'b0;
      bus.rx_i = 1'b1;
      set_idle();
   endtask

   // Every-cycle comparison of all DUT outputs against the model expectations
   initial begin
      fld_t got;
      forever begin
         @(posedge clk);
         #1;
         got = {bus.message_type_o, bus.local_address_o, bus.remote_address_o,
                bus.handshake_o, bus.atribute_o, bus.expand_count_o, bus.cmd_data_sign_o,
                bus.rtr_o, bus.dlc_o, bus.rx_data_o};
         chk("tx_o",       128'(bus.tx_o),            128'(e_tx));
         chk("rx_valid_o", 128'(bus.rx_valid_o),      128'(e_valid));
         chk("rx_error_o", 128'(bus.rx_error_o),      128'(e_err));
         chk("rx_busy_o",  128'(bus.rx_busy_o),       128'(e_busy));
         chk("error_code", 128'(bus.rx_error_code_o), 128'(e_code));
         chk("rx_match_o", 128'(bus.rx_match_o),      128'(e_match));
         chk("fields",     128'(got),                 128'(e_fld));
      end
   end

   initial begin
      fld_t f1, f0, ff, f2, f3;
      logic [14:0] c;
      logic [6:0]  sv;

      bus.rx_i = 1'b1;
      rst = 1'b1;

      f1 = '{mt: 1'b1, loc: 6'h15, rem: 6'h2A, hs: 2'b01, at: 2'b10, ex: 4'h3,
             cmd: 8'hA5, rtr: 1'b0, dlc: 4'h8, data: 64'h0123456789ABCDEF};
      f0 = f1; f0.data = 64'h0;
      ff = f1; ff.data = 64'hFFFF_FFFF_FFFF_FFFF;
      f2 = f1; f2.loc = 6'h01; f2.data = 64'hDEADBEEF00C0FFEE;
      f3 = '{mt: 1'b0, loc: 6'h2A, rem: 6'h15, hs: 2'b10, at: 2'b01, ex: 4'hC,
             cmd: 8'h5A, rtr: 1'b1, dlc: 4'h4, data: 64'h5555AAAA3333CCCC};

      // Hand-computed pins on the model itself
      c = crc_step(15'h0000, 1'b1);
      chk("model_crc_1", 128'(c), 128'(15'h4599));
      c = crc_step(c, 1'b0);
      chk("model_crc_10", 128'(c), 128'(15'h4EAB));
      raw_q.delete();
      for (int i = 0; i < 6; i++) raw_q.push_back(1'b0);
      do_stuff();
      sv = '0;
      foreach (wire_q[i]) sv = {sv[5:0], wire_q[i]};
      chk("model_stuff_len", 128'(wire_q.size()), 128'(7));
      chk("model_stuff_bits", 128'(sv), 128'(7'b0000010));
      build_raw(f1);
      chk("model_raw_len", 128'(raw_q.size()), 128'(103));

      do_reset(2);
      idle(3);

      build(f1, K_GOOD);  play(1000); idle(2);
      build(f0, K_GOOD);  play(1000); idle(2);
      build(ff, K_GOOD);  play(1000); idle(2);
      build(f0, K_STUFF); play(1000); idle(2);
      build(f1, K_GOOD);  play(1000); idle(2);
      build(f2, K_CRC);   play(1000); idle(2);
      build(f2, K_DELIM); play(1000); idle(2);
      build(f2, K_EOF);   play(1000); idle(2);

      build(f2, K_GOOD);  play(70);
      do_reset(1);
      idle(2);
      build(f1, K_GOOD);  play(1000);
      build(f3, K_GOOD);  play(1000);
      build(f1, K_GOOD);  play(1000);
      idle(4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
